// File: rtl/fm_demod.sv
// FM quadrature demodulator: angle of (current * conj(previous)) via a polynomial arctan
// approximation, with a multi-cycle restoring divider, one sample in and one sample out per pass.
module fm_demod #(
    parameter int DATA_SIZE = 32,
    parameter int BITS      = 10,
    parameter int GAIN      = 758,
    parameter int QUAD1     = 804,
    parameter int QUAD3     = 2412
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] real_in,
    input  logic [DATA_SIZE-1:0] imag_in,
    input  logic                 real_empty,
    input  logic                 imag_empty,
    output logic                 rd_en,
    output logic [DATA_SIZE-1:0] demod_out,
    input  logic                 out_full,
    output logic                 wr_en
);

    localparam int PW = 2 * DATA_SIZE;
    localparam int CW = $clog2(DATA_SIZE + 1);
    localparam logic signed [DATA_SIZE-1:0] C_QUAD1 = DATA_SIZE'(QUAD1);
    localparam logic signed [DATA_SIZE-1:0] C_QUAD3 = DATA_SIZE'(QUAD3);
    localparam logic signed [DATA_SIZE-1:0] C_GAIN  = DATA_SIZE'(GAIN);
    localparam logic signed [PW-1:0]        C_BIAS  = PW'((1 << BITS) - 1);

    typedef enum logic [2:0] {
        S_READ,
        S_CONJ,
        S_DIV_SETUP,
        S_DIV,
        S_ANGLE,
        S_WRITE
    } state_t;

    function automatic logic signed [PW-1:0] mul(input logic signed [DATA_SIZE-1:0] a,
                                                 input logic signed [DATA_SIZE-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    // Rounds toward zero: negative values get a bias of 2^BITS-1 before the arithmetic shift.
    function automatic logic signed [DATA_SIZE-1:0] dequant(input logic signed [PW-1:0] x);
        logic signed [PW-1:0] biased;
        biased = x[PW-1] ? x + C_BIAS : x;
        return DATA_SIZE'(biased >>> BITS);
    endfunction

    function automatic logic signed [DATA_SIZE-1:0] quant(input logic signed [DATA_SIZE-1:0] x);
        return x <<< BITS;
    endfunction

    state_t                        r_state;
    logic signed [DATA_SIZE-1:0]   r_cur_real, r_cur_imag;
    logic signed [DATA_SIZE-1:0]   r_prev_real, r_prev_imag;
    logic signed [DATA_SIZE-1:0]   r_r, r_i, r_result;
    logic        [DATA_SIZE-1:0]   r_div_quot, r_div_den, r_div_rem;
    logic                          r_q_neg;
    logic        [CW-1:0]          r_div_cnt;

    logic signed [DATA_SIZE-1:0]   w_neg_prev_imag, w_conj_r, w_conj_i;
    logic signed [DATA_SIZE-1:0]   w_abs_y, w_num, w_den;
    logic        [DATA_SIZE-1:0]   w_num_mag, w_den_mag;
    logic        [DATA_SIZE:0]     w_rem_shift, w_rem_diff;
    logic                          w_fits;
    logic signed [DATA_SIZE-1:0]   w_quot, w_angle_base, w_angle_raw, w_angle, w_result;

    assign w_neg_prev_imag = -r_prev_imag;
    assign w_conj_r = dequant(mul(r_cur_real, r_prev_real)) - dequant(mul(r_cur_imag, w_neg_prev_imag));
    assign w_conj_i = dequant(mul(r_cur_real, w_neg_prev_imag)) + dequant(mul(r_cur_imag, r_prev_real));

    // The +1 keeps the denominator strictly positive, so the divider needs no zero check.
    assign w_abs_y   = (r_i[DATA_SIZE-1] ? -r_i : r_i) + DATA_SIZE'(1);
    assign w_num     = r_r[DATA_SIZE-1] ? quant(r_r + w_abs_y) : quant(r_r - w_abs_y);
    assign w_den     = r_r[DATA_SIZE-1] ? (w_abs_y - r_r) : (r_r + w_abs_y);
    assign w_num_mag = w_num[DATA_SIZE-1] ? -w_num : w_num;
    assign w_den_mag = w_den[DATA_SIZE-1] ? -w_den : w_den;

    assign w_rem_shift = {r_div_rem, r_div_quot[DATA_SIZE-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_div_den};
    assign w_fits      = ~w_rem_diff[DATA_SIZE];

    assign w_quot       = r_q_neg ? -r_div_quot : r_div_quot;
    assign w_angle_base = r_r[DATA_SIZE-1] ? C_QUAD3 : C_QUAD1;
    assign w_angle_raw  = w_angle_base - dequant(mul(C_QUAD1, w_quot));
    assign w_angle      = r_i[DATA_SIZE-1] ? -w_angle_raw : w_angle_raw;
    assign w_result     = dequant(mul(C_GAIN, w_angle));

    // NOTE: the FIFO strobes are combinational so a pop/push lands in the same cycle the flag is seen.
    assign rd_en     = ~reset && (r_state == S_READ) && ~real_empty && ~imag_empty;
    assign wr_en     = (r_state == S_WRITE) && ~out_full;
    assign demod_out = r_result;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_READ;
            r_cur_real  <= '0;
            r_cur_imag  <= '0;
            r_prev_real <= '0;
            r_prev_imag <= '0;
            r_r         <= '0;
            r_i         <= '0;
            r_result    <= '0;
            r_div_quot  <= '0;
            r_div_den   <= '0;
            r_div_rem   <= '0;
            r_q_neg     <= 1'b0;
            r_div_cnt   <= '0;
        end else begin
            case (r_state)
                S_READ: begin
                    if (~real_empty && ~imag_empty) begin
                        r_cur_real <= real_in;
                        r_cur_imag <= imag_in;
                        r_state    <= S_CONJ;
                    end
                end
                S_CONJ: begin
                    r_r         <= w_conj_r;
                    r_i         <= w_conj_i;
                    r_prev_real <= r_cur_real;
                    r_prev_imag <= r_cur_imag;
                    r_state     <= S_DIV_SETUP;
                end
                S_DIV_SETUP: begin
                    r_div_quot <= w_num_mag;
                    r_div_den  <= w_den_mag;
                    r_div_rem  <= '0;
                    r_q_neg    <= w_num[DATA_SIZE-1] ^ w_den[DATA_SIZE-1];
                    r_div_cnt  <= '0;
                    r_state    <= S_DIV;
                end
                S_DIV: begin
                    // Dividend bits shift out of the top of r_div_quot as quotient bits shift in.
                    r_div_rem  <= w_fits ? w_rem_diff[DATA_SIZE-1:0] : w_rem_shift[DATA_SIZE-1:0];
                    r_div_quot <= {r_div_quot[DATA_SIZE-2:0], w_fits};
                    r_div_cnt  <= r_div_cnt + CW'(1);
                    if (r_div_cnt == CW'(DATA_SIZE - 1)) begin
                        r_state <= S_ANGLE;
                    end
                end
                S_ANGLE: begin
                    r_result <= w_result;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    if (~out_full) begin
                        r_state <= S_READ;
                    end
                end
                default: r_state <= S_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_demod.sv
// Directed bench for fm_demod: a scoreboard queue is filled when a sample is popped
// and drained when wr_en fires; latency, throughput, back-pressure and reset abort are checked.
module tb_fm_demod;

    localparam int DS = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [DS-1:0] real_in, imag_in, demod_out;
    logic          real_empty, imag_empty, rd_en, out_full, wr_en;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_q[$];
    int mp_re = 0;
    int mp_im = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    fm_demod dut (
        .clock      (clock),
        .reset      (reset),
        .real_in    (real_in),
        .imag_in    (imag_in),
        .real_empty (real_empty),
        .imag_empty (imag_empty),
        .rd_en      (rd_en),
        .demod_out  (demod_out),
        .out_full   (out_full),
        .wr_en      (wr_en)
    );

    // Reference model with default parameters; SV integer division truncates toward zero.
    function automatic int model(input int cr, input int ci, input int pr, input int pi);
        int npi, r, i, ay, num, den, q, ang;
        npi = -pi;
        r = int'((longint'(cr) * longint'(pr)) / 1024) - int'((longint'(ci) * longint'(npi)) / 1024);
        i = int'((longint'(cr) * longint'(npi)) / 1024) + int'((longint'(ci) * longint'(pr)) / 1024);
        ay = ((i < 0) ? -i : i) + 1;
        if (r >= 0) begin
            num = (r - ay) * 1024;
            den = r + ay;
        end else begin
            num = (r + ay) * 1024;
            den = ay - r;
        end
        q   = num / den;
        ang = ((r >= 0) ? 804 : 2412) - int'((longint'(804) * longint'(q)) / 1024);
        if (i < 0) ang = -ang;
        return int'((longint'(758) * longint'(ang)) / 1024);
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode: 0 = no expectation (sample will be aborted), 1 = model, 2 = literal value
    task automatic feed(input int re, input int im, input int mode, input int lit, output int at);
        int n;
        real_in    = re;
        imag_in    = im;
        real_empty = 1'b0;
        imag_empty = 1'b0;
        at = -1;
        n  = 0;
        while (at < 0 && n < 200) begin
            @(negedge clock);
            if (rd_en === 1'b1) at = cyc;
            n++;
        end
        check("rd_seen", rd_en, 1);
        if (mode == 1) exp_q.push_back(model(re, im, mp_re, mp_im));
        else if (mode == 2) exp_q.push_back(lit);
        mp_re = re;
        mp_im = im;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_wr(input string tag, input int rd_at, input int lat);
        int n       = 0;
        int rd_hits = 0;
        int e;
        do begin
            @(negedge clock);
            n++;
            if (wr_en !== 1'b1 && rd_en === 1'b1) rd_hits++;
        end while (wr_en !== 1'b1 && n < 200);
        check({tag, "_wr_seen"}, wr_en, 1);
        check({tag, "_rd_wr_excl"}, rd_en, 0);
        check({tag, "_latency"}, cyc - rd_at, lat);
        check({tag, "_rd_quiet"}, rd_hits, 0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        check(tag, $signed(demod_out), e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int at, prev_at, hits, e, re, im;

        // Reset state, with both FIFOs reporting data to prove rd_en is held off.
        reset      = 1'b1;
        real_in    = '0;
        imag_in    = '0;
        real_empty = 1'b0;
        imag_empty = 1'b0;
        out_full   = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_demod_out", $signed(demod_out), 0);
        real_empty = 1'b1;
        imag_empty = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // First sample against prev = (0,0).
        feed(0, 0, 2, 1190, at);
        real_empty = 1'b1; imag_empty = 1'b1;
        wait_wr("zero", at, 36);

        feed(1024, 0, 1, 0, at);
        real_empty = 1'b1; imag_empty = 1'b1;
        wait_wr("pos_a", at, 36);
        feed(1024, 0, 2, 1, at);
        real_empty = 1'b1; imag_empty = 1'b1;
        wait_wr("same_phase", at, 36);

        feed(0, -1024, 2, -1190, at);
        real_empty = 1'b1; imag_empty = 1'b1;
        wait_wr("neg_quarter", at, 36);

        feed(1024, 0, 1, 0, at);
        real_empty = 1'b1; imag_empty = 1'b1;
        wait_wr("pos_b", at, 36);
        feed(-1024, 0, 2, 2379, at);
        real_empty = 1'b1; imag_empty = 1'b1;
        wait_wr("half_turn", at, 36);

        // Reset during the divide: no output, result cleared, history cleared.
        feed(1024, 0, 0, 0, at);
        real_empty = 1'b1; imag_empty = 1'b1;
        repeat (10) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("abort_rd_en", rd_en, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_demod_out", $signed(demod_out), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        mp_re = 0;
        mp_im = 0;
        hits  = 0;
        repeat (50) begin
            @(negedge clock);
            if (wr_en === 1'b1) hits++;
        end
        check("abort_no_wr", hits, 0);
        @(posedge clock);
        #1;
        feed(1024, 0, 2, 1190, at);
        real_empty = 1'b1; imag_empty = 1'b1;
        wait_wr("post_abort_a", at, 36);
        feed(0, 0, 2, 1190, at);
        real_empty = 1'b1; imag_empty = 1'b1;
        wait_wr("post_abort_b", at, 36);

        // Back-pressure: ten stalled WRITE cycles, then a single push on release.
        out_full = 1'b1;
        feed(300, -200, 1, 0, at);
        real_empty = 1'b1; imag_empty = 1'b1;
        e = (exp_q.size() > 0) ? exp_q[0] : 0;
        while (cyc < at + 36) @(negedge clock);
        for (int j = 0; j < 10; j++) begin
            if (j > 0) @(negedge clock);
            check("stall_wr_low", wr_en, 0);
            check("stall_hold", $signed(demod_out), e);
        end
        @(posedge clock);
        #1 out_full = 1'b0;
        wait_wr("stall_release", at, 46);
        hits = 0;
        repeat (5) begin
            @(negedge clock);
            if (wr_en === 1'b1) hits++;
        end
        check("single_pulse", hits, 0);

        // Only one FIFO has data: no pop.
        hits = 0;
        real_empty = 1'b0; imag_empty = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (rd_en === 1'b1) hits++;
        end
        real_empty = 1'b1; imag_empty = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (rd_en === 1'b1) hits++;
        end
        check("one_empty_no_rd", hits, 0);
        check("one_empty_no_wr", wr_en, 0);
        imag_empty = 1'b1;
        @(posedge clock);
        #1;

        // Streaming with FIFOs never empty: flags outside READ are ignored, one sample per 37 cycles.
        prev_at = 0;
        for (int s = 0; s < 6; s++) begin
            re = int'($urandom_range(8192, 0)) - 4096;
            im = int'($urandom_range(8192, 0)) - 4096;
            feed(re, im, 1, 0, at);
            if (s > 0) check("throughput", at - prev_at, 37);
            prev_at = at;
            real_in = $urandom;
            imag_in = $urandom;
            wait_wr("stream", at, 36);
        end
        real_empty = 1'b1;
        imag_empty = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fm_demod.md
FM_DEMOD -- requirements
Module: fm_demod

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32: width of all sample ports and arithmetic registers.
REQ-002 SHALL have parameter BITS, default 10: fixed-point fraction bits (QUANT = shift left BITS; DEQUANT = truncate toward zero after shift right BITS).
REQ-003 SHALL have parameter GAIN, default 758: quantized demod gain.
REQ-004 SHALL have parameters QUAD1, default 804, and QUAD3, default 2412: quantized pi/4 and 3pi/4.
REQ-005 SHALL have port clock, input, 1 bit: rising-edge system clock.
REQ-006 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port real_in, input, DATA_SIZE bits: signed I sample from the I FIFO.
REQ-008 SHALL have port imag_in, input, DATA_SIZE bits: signed Q sample from the Q FIFO.
REQ-009 SHALL have port real_empty and imag_empty, input, 1 bit each: FIFO empty flags.
REQ-010 SHALL have port rd_en, output, 1 bit: common pop strobe to both input FIFOs.
REQ-011 SHALL have port demod_out, output, DATA_SIZE bits: signed demodulated sample to the de-emphasis IIR input FIFO.
REQ-012 SHALL have port out_full, input, 1 bit, and wr_en, output, 1 bit: output FIFO full flag and push strobe.

Function
REQ-013 SHALL implement states READ, CONJ, DIV_SETUP, DIV, ANGLE, WRITE; any illegal encoding -> READ.
REQ-014 READ: rd_en = 1 combinationally only when real_empty = 0 and imag_empty = 0; on that cycle SHALL latch real_in/imag_in and go to CONJ; else stay in READ with rd_en = 0.
REQ-015 CONJ: SHALL compute r = DEQUANT(real*prev_real) - DEQUANT(imag*(-prev_imag)) and i = DEQUANT(real*(-prev_imag)) + DEQUANT(imag*prev_real); 64-bit signed products, result truncated to DATA_SIZE; then prev_real/prev_imag <= current sample; go to DIV_SETUP.
REQ-016 DIV_SETUP: abs_y = |i| + 1; if r >= 0, num = QUANT(r - abs_y), den = r + abs_y; else num = QUANT(r + abs_y), den = abs_y - r; QUANT wraps at DATA_SIZE bits; go to DIV.
REQ-017 DIV: SHALL run a sequential restoring divide on magnitudes, one quotient bit per cycle, exactly DATA_SIZE cycles, quotient sign = sign(num) xor sign(den), truncated toward zero; den >= 1 by construction, so no divide-by-zero path exists.
REQ-018 ANGLE: angle = (r >= 0 ? QUAD1 : QUAD3) - DEQUANT(QUAD1*q); negated if i < 0; result register = DEQUANT(GAIN*angle); go to WRITE.
REQ-019 WRITE: if out_full = 0, SHALL drive wr_en = 1 and demod_out = result for exactly one cycle, then go to READ; if out_full = 1, hold WRITE with wr_en = 0 and demod_out stable.
REQ-020 With no back-pressure, wr_en SHALL assert exactly DATA_SIZE+4 = 36 cycles after the rd_en cycle; throughput one sample per 37 cycles.
REQ-021 SHALL never assert rd_en outside READ nor wr_en outside WRITE; rd_en and wr_en never high in the same cycle.
REQ-022 Empty flags changing outside READ SHALL have no effect.

Reset
REQ-023 On reset: state = READ; rd_en = 0, wr_en = 0, demod_out = 0; prev_real = prev_imag = 0; divider, r, i, result registers = 0.
REQ-024 Reset asserted mid-computation or in WRITE SHALL abort the sample with no wr_en pulse; first sample after reset is processed against prev = (0,0).

Verification
REQ-025 After reset, sample (0,0) -> r=0, i=0, q=-1024, angle 1608, demod_out = 1190, wr_en 36 cycles after rd_en.
REQ-026 Samples (1024,0) then (1024,0) -> second output: r=1024, i=0, q=1022, angle 2, demod_out = 1.
REQ-027 Samples (1024,0) then (0,-1024) -> second output: i=-1024, angle -1608, demod_out = -1190.
REQ-028 Samples (1024,0) then (-1024,0) -> second output: r=-1024, q=-1022, angle 3214, demod_out = 2379.
REQ-029 out_full held high 10 cycles in WRITE -> wr_en low, demod_out stable, single wr_en pulse on release; only one of real_empty/imag_empty low -> rd_en stays 0.
REQ-030 Reset pulsed during DIV -> no wr_en, next sample (0,0) yields demod_out = 1190.
